nark_dmem_arbiter: RTL and testbench
====================================

Name: nark_dmem_arbiter

Overview:
- Two-port arbiter in front of the single-ported NARK kernel data memory.
- Requester P is the pipeline memory stage. Requester L is the program/data loader (debug/boot DMA).
- Fixed priority goes to P. An anti-starvation counter forces a grant to L after STARVE_LIMIT consecutive denied cycles.
- Stalls the pipeline while P is denied. Returns read data registered, one cycle after grant, matching the M-stage register timing.

Parameters:
- BITS, 24, data and address width.
- STARVE_LIMIT, 4, consecutive denied L cycles before L is forced; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- P_Req  input  1  pipeline access request.
- P_WE  input  1  pipeline write enable (1 = write, 0 = read).
- P_Addr  input  BITS  pipeline address (ALU result).
- P_WData  input  BITS  pipeline write data.
- P_Gnt  output  1  pipeline granted this cycle (combinational).
- P_Stall  output  1  P_Req & ~P_Gnt; freezes the E/M pipeline registers.
- P_RValid  output  1  registered; read data valid.
- P_RData  output  BITS  registered read data.
- L_Req  input  1  loader access request.
- L_WE  input  1  loader write enable.
- L_Addr  input  BITS  loader address.
- L_WData  input  BITS  loader write data.
- L_Gnt  output  1  loader granted this cycle (combinational).
- L_RValid  output  1  registered; read data valid.
- L_RData  output  BITS  registered read data.
- MemAddr  output  BITS  to kernel memory address.
- MemWE  output  1  to kernel memory write enable.
- MemWData  output  BITS  to kernel memory write data.
- MemRData  input  BITS  from kernel memory; combinational read of MemAddr.

Behaviour:
- Single clock CLK. RST is synchronous and active-high; it is sampled on the CLK rising edge only.
- Reset clears: StarveCnt = 0, P_RValid = 0, L_RValid = 0, P_RData = 0, L_RData = 0.
- Outputs in reset: grants are combinational and follow the rules below even while RST is high, but MemWE is forced to 0 while RST = 1.
- Force condition: ForceL = L_Req & (StarveCnt == STARVE_LIMIT).
- Grant rule (combinational):
  - L_Gnt = L_Req & (~P_Req | ForceL).
  - P_Gnt = P_Req & ~L_Gnt.
  - At most one grant per cycle.
- Memory mux:
  - If L_Gnt: drive L_Addr, L_WE, L_WData.
  - Else if P_Gnt: drive P_Addr, P_WE, P_WData.
  - Else: MemAddr = P_Addr, MemWE = 0, MemWData = 0.
- Starvation counter (4-bit StarveCnt), updated each CLK edge:
  - RST, L_Gnt, or ~L_Req: clear to 0.
  - Else (L_Req & ~L_Gnt): increment, saturating at STARVE_LIMIT.
  - So L waits at most STARVE_LIMIT cycles, then is granted in cycle STARVE_LIMIT+1.
- Read return, latency 1:
  - On the edge after a granted read (Gnt & ~WE), the owner's RValid = 1 and RData = MemRData sampled at that edge.
  - Otherwise RValid = 0 and RData holds its last value.
- Writes: commit in the granted cycle. They produce no RValid.
- Back-to-back: a requester may be granted every cycle. RValid pulses each cycle for consecutive reads.
- Requester contract: holds Req/WE/Addr/WData stable until Gnt. Dropping Req before Gnt is allowed and clears StarveCnt if L drops.
- Simultaneous reads and writes to the same address from P and L: only the granted one executes; the other retries next cycle and observes the updated memory.
- Reset mid-operation: a read granted in the same cycle RST is high returns RValid = 0. A pending forced L grant is lost and the count restarts.

Test Plan:
- Reset: hold RST high 2 cycles with P_Req = 1, P_WE = 1 -> MemWE = 0; after release, all RValid = 0 and RData = 0.
- P only: P write 0x00ABCD to addr 5, next cycle P read addr 5 -> P_Gnt = 1 both cycles, P_Stall = 0, P_RValid = 1 with P_RData = 0x00ABCD one cycle after the read.
- L only: L reads addr 5 three consecutive cycles -> L_Gnt every cycle, L_RValid high 3 cycles, L_RData = 0x00ABCD.
- Contention, STARVE_LIMIT = 4, P_Req and L_Req held high:
  - P granted cycles 0-3, L granted cycle 4, P_Stall = 1 only in cycle 4.
  - Pattern repeats with period 5.
- L drops its request at cycle 2 of waiting and reasserts -> StarveCnt restarts from 0; L is granted 4 cycles after reassert.
- Same-address race: P write 0x111111 to addr 9 and L read addr 9 in the same cycle (no force) -> P write commits; L granted next cycle and reads 0x111111.

Source files
------------

// File: rtl/nark_dmem_arbiter.sv
// Arbitrates the NARK kernel data memory between the pipeline M-stage (P) and the loader (L).
// P has fixed priority. L is forced through after STARVE_LIMIT consecutive denied cycles.
module nark_dmem_arbiter #(
    parameter int BITS         = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            P_Req,
    input  logic            P_WE,
    input  logic [BITS-1:0] P_Addr,
    input  logic [BITS-1:0] P_WData,
    output logic            P_Gnt,
    output logic            P_Stall,
    output logic            P_RValid,
    output logic [BITS-1:0] P_RData,
    input  logic            L_Req,
    input  logic            L_WE,
    input  logic [BITS-1:0] L_Addr,
    input  logic [BITS-1:0] L_WData,
    output logic            L_Gnt,
    output logic            L_RValid,
    output logic [BITS-1:0] L_RData,
    output logic [BITS-1:0] MemAddr,
    output logic            MemWE,
    output logic [BITS-1:0] MemWData,
    input  logic [BITS-1:0] MemRData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            force_l;
    logic            p_rvalid_q, p_rvalid_d;
    logic            l_rvalid_q, l_rvalid_d;
    logic [BITS-1:0] p_rdata_q, p_rdata_d;
    logic [BITS-1:0] l_rdata_q, l_rdata_d;

    assign force_l = L_Req & (starve_cnt_q == LIMIT);
    assign L_Gnt   = L_Req & (~P_Req | force_l);
    assign P_Gnt   = P_Req & ~L_Gnt;
    assign P_Stall = P_Req & ~P_Gnt;

    always_comb begin
        MemAddr  = P_Addr;
        MemWE    = 1'b0;
        MemWData = '0;
        if (L_Gnt) begin
            MemAddr  = L_Addr;
            MemWE    = L_WE;
            MemWData = L_WData;
        end else if (P_Gnt) begin
            MemAddr  = P_Addr;
            MemWE    = P_WE;
            MemWData = P_WData;
        end
        // Never let a write reach the memory while the arbiter is held in reset.
        if (RST) MemWE = 1'b0;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (L_Gnt || !L_Req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        p_rvalid_d = P_Gnt & ~P_WE;
        l_rvalid_d = L_Gnt & ~L_WE;
        p_rdata_d  = p_rvalid_d ? MemRData : p_rdata_q;
        l_rdata_d  = l_rvalid_d ? MemRData : l_rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_q <= '0;
            p_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
            p_rdata_q    <= '0;
            l_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            p_rvalid_q   <= p_rvalid_d;
            l_rvalid_q   <= l_rvalid_d;
            p_rdata_q    <= p_rdata_d;
            l_rdata_q    <= l_rdata_d;
        end
    end

    assign P_RValid = p_rvalid_q;
    assign P_RData  = p_rdata_q;
    assign L_RValid = l_rvalid_q;
    assign L_RData  = l_rdata_q;

endmodule

// File: tb/tb_nark_dmem_arbiter.sv
// Directed bench for nark_dmem_arbiter with a small behavioural kernel memory behind it.
module tb_nark_dmem_arbiter;

    localparam int BITS = 24;

    logic            CLK;
    logic            RST;
    logic            P_Req, P_WE;
    logic [BITS-1:0] P_Addr, P_WData;
    logic            P_Gnt, P_Stall, P_RValid;
    logic [BITS-1:0] P_RData;
    logic            L_Req, L_WE;
    logic [BITS-1:0] L_Addr, L_WData;
    logic            L_Gnt, L_RValid;
    logic [BITS-1:0] L_RData;
    logic [BITS-1:0] MemAddr, MemWData, MemRData;
    logic            MemWE;

    logic [BITS-1:0] mem [16];

    int checks   = 0;
    int failures = 0;

    nark_dmem_arbiter #(.BITS(BITS), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .P_Req(P_Req), .P_WE(P_WE), .P_Addr(P_Addr), .P_WData(P_WData),
        .P_Gnt(P_Gnt), .P_Stall(P_Stall), .P_RValid(P_RValid), .P_RData(P_RData),
        .L_Req(L_Req), .L_WE(L_WE), .L_Addr(L_Addr), .L_WData(L_WData),
        .L_Gnt(L_Gnt), .L_RValid(L_RValid), .L_RData(L_RData),
        .MemAddr(MemAddr), .MemWE(MemWE), .MemWData(MemWData), .MemRData(MemRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Kernel memory: combinational read, write on the rising edge.
    assign MemRData = mem[MemAddr[3:0]];
    always @(posedge CLK) if (MemWE) mem[MemAddr[3:0]] <= MemWData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        RST = 1'b1;
        P_Req = 1'b1; P_WE = 1'b1; P_Addr = 24'd3; P_WData = 24'h00005A;
        L_Req = 1'b0; L_WE = 1'b0; L_Addr = '0;   L_WData = '0;

        // Reset held two cycles with a P write pending.
        #3;
        chk("rst_memwe_0", MemWE, 1'b0);
        chk("rst_pgnt", P_Gnt, 1'b1);
        cyc();
        #3;
        chk("rst_memwe_1", MemWE, 1'b0);
        cyc();
        RST = 1'b0; P_Req = 1'b0; P_WE = 1'b0;
        chk("rst_prvalid", P_RValid, 1'b0);
        chk("rst_lrvalid", L_RValid, 1'b0);
        chk("rst_prdata", P_RData, 24'h0);
        chk("rst_lrdata", L_RData, 24'h0);
        #3;
        chk("idle_memwe", MemWE, 1'b0);
        chk("idle_memwdata", MemWData, 24'h0);
        chk("rst_no_write", mem[3], 24'h0);
        cyc();

        // P only: write then read back.
        P_Req = 1'b1; P_WE = 1'b1; P_Addr = 24'd5; P_WData = 24'h00ABCD;
        #3;
        chk("pw_gnt", P_Gnt, 1'b1);
        chk("pw_stall", P_Stall, 1'b0);
        chk("pw_memwe", MemWE, 1'b1);
        chk("pw_memaddr", MemAddr, 24'd5);
        cyc();
        chk("pw_no_rvalid", P_RValid, 1'b0);
        P_WE = 1'b0;
        #3;
        chk("pr_gnt", P_Gnt, 1'b1);
        chk("pr_stall", P_Stall, 1'b0);
        cyc();
        chk("pr_rvalid", P_RValid, 1'b1);
        chk("pr_rdata", P_RData, 24'h00ABCD);
        P_Req = 1'b0;
        cyc();
        chk("pr_rvalid_off", P_RValid, 1'b0);
        chk("pr_rdata_hold", P_RData, 24'h00ABCD);

        // L only: three back-to-back reads.
        L_Req = 1'b1; L_WE = 1'b0; L_Addr = 24'd5;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("lr_gnt", L_Gnt, 1'b1);
            cyc();
            chk("lr_rvalid", L_RValid, 1'b1);
            chk("lr_rdata", L_RData, 24'h00ABCD);
        end
        L_Req = 1'b0;
        cyc();
        chk("lr_rvalid_off", L_RValid, 1'b0);

        // Contention: P granted 4 cycles, L forced on the 5th, period 5.
        P_Req = 1'b1; P_WE = 1'b0; P_Addr = 24'd5;
        L_Req = 1'b1; L_WE = 1'b0; L_Addr = 24'd5;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("ct_lgnt", L_Gnt, (i % 5) == 4);
            chk("ct_pgnt", P_Gnt, (i % 5) != 4);
            chk("ct_pstall", P_Stall, (i % 5) == 4);
            cyc();
        end
        P_Req = 1'b0; L_Req = 1'b0;
        cyc();

        // L drops its request while waiting: count restarts on reassert.
        P_Req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            L_Req = (c != 2);
            #3;
            chk("drop_lgnt", L_Gnt, c == 7);
            cyc();
        end
        P_Req = 1'b0; L_Req = 1'b0;
        cyc();

        // Same-address race: P write wins, L reads the new value next cycle.
        P_Req = 1'b1; P_WE = 1'b1; P_Addr = 24'd9; P_WData = 24'h111111;
        L_Req = 1'b1; L_WE = 1'b0; L_Addr = 24'd9;
        #3;
        chk("race_pgnt", P_Gnt, 1'b1);
        chk("race_lgnt0", L_Gnt, 1'b0);
        cyc();
        P_Req = 1'b0; P_WE = 1'b0;
        #3;
        chk("race_lgnt1", L_Gnt, 1'b1);
        chk("race_memaddr", MemAddr, 24'd9);
        cyc();
        chk("race_lrvalid", L_RValid, 1'b1);
        chk("race_lrdata", L_RData, 24'h111111);

        // Read granted while reset is asserted returns nothing.
        RST = 1'b1;
        L_Addr = 24'd5;
        #3;
        chk("rstmid_lgnt", L_Gnt, 1'b1);
        cyc();
        chk("rstmid_lrvalid", L_RValid, 1'b0);
        chk("rstmid_lrdata", L_RData, 24'h0);
        RST = 1'b0; L_Req = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
